// File: rtl/serial_pattern_gen.sv
// Serial bit-pattern transmitter: sends a captured WIDTH-bit pattern MSB-first, repeat_n+1 times,
// with GAP_CYCLES idle bit-times between copies. Define PATGEN_PARITY_EN to append an even-parity bit per copy.
module serial_pattern_gen #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned GAP_CYCLES = 0,
  parameter logic        IDLE_BIT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BIT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
  localparam logic [BIT_W-1:0] BIT_LAST_V = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST_V = GAP_W'(GAP_LAST);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_GAP  = 3'd2,
`ifdef PATGEN_PARITY_EN
    ST_PAR  = 3'd4,
`endif
    ST_DONE = 3'd3
  } state_t;

`ifdef PATGEN_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction
`endif

  state_t             state_q, state_d;
  logic               out_q, out_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   pat_q, pat_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   copy_cnt_q, copy_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               copy_end_s;

  // Next-state and next-output computation; outputs describe the cycle after the coming edge.
  always_comb begin
    state_d    = state_q;
    out_d      = IDLE_BIT;
    valid_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    shreg_d    = shreg_q;
    pat_d      = pat_q;
    bit_cnt_d  = bit_cnt_q;
    copy_cnt_d = copy_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    copy_end_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SEND;
          pat_d      = pattern;
          shreg_d    = pattern;
          copy_cnt_d = repeat_n;
          bit_cnt_d  = '0;
          out_d      = pattern[WIDTH-1];
          valid_d    = 1'b1;
          busy_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (bit_cnt_q != BIT_LAST_V) begin
          shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
          out_d     = shreg_q[WIDTH-2];
          valid_d   = 1'b1;
          busy_d    = 1'b1;
        end else begin
`ifdef PATGEN_PARITY_EN
          state_d = ST_PAR;
          out_d   = even_parity(pat_q);
          valid_d = 1'b1;
          busy_d  = 1'b1;
`else
          copy_end_s = 1'b1;
`endif
        end
      end
`ifdef PATGEN_PARITY_EN
      ST_PAR: begin
        copy_end_s = 1'b1;
      end
`endif
      ST_GAP: begin
        busy_d = 1'b1;
        if (gap_cnt_q == GAP_LAST_V) begin
          state_d   = ST_SEND;
          gap_cnt_d = '0;
          bit_cnt_d = '0;
          out_d     = shreg_q[WIDTH-1];
          valid_d   = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A copy has finished: either finish the transmission or reload from the captured copy.
    if (copy_end_s) begin
      if (copy_cnt_q == '0) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        copy_cnt_d = copy_cnt_q - 1'b1;
        shreg_d    = pat_q;
        bit_cnt_d  = '0;
        busy_d     = 1'b1;
        if (GAP_CYCLES > 0) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end else begin
          state_d = ST_SEND;
          out_d   = pat_q[WIDTH-1];
          valid_d = 1'b1;
        end
      end
    end else begin
      copy_cnt_d = copy_cnt_d;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      out_q      <= IDLE_BIT;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      shreg_q    <= '0;
      pat_q      <= '0;
      bit_cnt_q  <= '0;
      copy_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      shreg_q    <= shreg_d;
      pat_q      <= pat_d;
      bit_cnt_q  <= bit_cnt_d;
      copy_cnt_q <= copy_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
